// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction inputs and datapath control strobes between sequencer and datapath
interface control_sequencer_if;
  logic        Run;
  logic        MemReady;
  logic [31:0] IR;
  logic        PCout;
  logic        ZLOout;
  logic        MDRout;
  logic        MARin;
  logic        Zin;
  logic        PCin;
  logic        MDRin;
  logic        IRin;
  logic        Yin;
  logic        IncrementPC;
  logic        Read;
  logic [4:0]  ALUControl;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        Done;
  logic        Fault;
  modport master (
    input  Run, MemReady, IR,
    output PCout, ZLOout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncrementPC, Read,
    output ALUControl, Rin, Rout, Done, Fault
  );
  modport slave (
    output Run, MemReady, IR,
    input  PCout, ZLOout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncrementPC, Read,
    input  ALUControl, Rin, Rout, Done, Fault
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: Moore FSM stepping fetch/decode/execute strobes for a three-register ALU datapath
module control_sequencer (
  input logic Clock,
  input logic Resetn,
  control_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, FAULT} state_t;
  state_t state, state_nxt;
  logic t1_repeat;
  logic [4:0] opcode;
  logic [4:0] alu_code;
  logic legal;
  assign opcode = bus.IR[31:27];
  always_comb begin
    alu_code = opcode == 5'b00011 ? 5'b00011 :
               opcode == 5'b00100 ? 5'b00100 :
               opcode == 5'b00101 ? 5'b01100 :
               opcode == 5'b00110 ? 5'b01011 : 5'b00000;
    legal = alu_code != 5'b00000;
  end
  // t1_repeat marks any T1 cycle after the first, so the PC bumps once per fetch
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      t1_repeat <= 1'b0;
    end else begin
      state     <= state_nxt;
      t1_repeat <= state == T1;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.Run ? T0 : IDLE;
      T0:      state_nxt = T1;
      T1:      state_nxt = bus.MemReady ? T2 : T1;
      T2:      state_nxt = T3;
      T3:      state_nxt = legal ? T4 : FAULT;
      T4:      state_nxt = T5;
      T5:      state_nxt = bus.Run ? T0 : IDLE;
      default: state_nxt = FAULT;
    endcase
  end
  always_comb begin
    bus.PCout       = state == T0;
    bus.MARin       = state == T0;
    bus.Zin         = state == T0 || state == T4;
    bus.ZLOout      = state == T1 || state == T5;
    bus.Read        = state == T1;
    bus.MDRin       = state == T1;
    bus.PCin        = state == T1 && !t1_repeat;
    bus.IncrementPC = state == T1 && !t1_repeat;
    bus.MDRout      = state == T2;
    bus.IRin        = state == T2;
    bus.Yin         = state == T3;
    bus.ALUControl  = state == T4 ? alu_code : 5'b00000;
    bus.Rout        = state == T3 ? 16'h1 << bus.IR[22:19] :
                      state == T4 ? 16'h1 << bus.IR[18:15] : 16'h0;
    bus.Rin         = state == T5 ? 16'h1 << bus.IR[26:23] : 16'h0;
    bus.Done        = state == T5;
    bus.Fault       = state == FAULT;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed instructions; expected per-cycle strobe vectors are queued and checked by a monitor
module tb_control_sequencer;
  logic Clock = 1'b0;
  logic Resetn = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [49:0] q[$];
  logic [49:0] act;
  logic [49:0] e;
  localparam logic [10:0] S_T0  = 11'b10011000000;
  localparam logic [10:0] S_T1F = 11'b01000110011;
  localparam logic [10:0] S_T1W = 11'b01000010001;
  localparam logic [10:0] S_T2  = 11'b00100001000;
  localparam logic [10:0] S_T3  = 11'b00000000100;
  localparam logic [10:0] S_T4  = 11'b00001000000;
  localparam logic [10:0] S_T5  = 11'b01000000000;
  control_sequencer_if bus ();
  control_sequencer dut (.Clock(Clock), .Resetn(Resetn), .bus(bus));
  always #5 Clock = ~Clock;
  assign act = {bus.Fault, bus.Done, bus.Rout, bus.Rin, bus.ALUControl,
                bus.PCout, bus.ZLOout, bus.MDRout, bus.MARin, bus.Zin, bus.PCin,
                bus.MDRin, bus.IRin, bus.Yin, bus.IncrementPC, bus.Read};
  function automatic logic [49:0] ev(input logic [10:0] s, input logic [4:0] alu,
                                     input logic [15:0] rin, input logic [15:0] rout,
                                     input logic done, input logic fault);
    return {fault, done, rout, rin, alu, s};
  endfunction
  task automatic chk(input string nm, input logic [49:0] a, input logic [49:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s at %0t: got=%h exp=%h", nm, $time, a, x);
    end
  endtask
  always @(negedge Clock) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("seq", act, e);
    end else
      chk("quiet", act, '0);
  end
  // kind: 0 normal, 1 illegal opcode (runs into FAULT), 2 reset during T4
  task automatic run_instr(input logic [31:0] ir, input int waits, input bit hold,
                           input logic [4:0] alu, input logic [15:0] ra,
                           input logic [15:0] rb, input logic [15:0] rc, input int kind);
    int n;
    q.push_back(ev(S_T0, 5'b0, 16'h0, 16'h0, 1'b0, 1'b0));
    q.push_back(ev(S_T1F, 5'b0, 16'h0, 16'h0, 1'b0, 1'b0));
    repeat (waits) q.push_back(ev(S_T1W, 5'b0, 16'h0, 16'h0, 1'b0, 1'b0));
    q.push_back(ev(S_T2, 5'b0, 16'h0, 16'h0, 1'b0, 1'b0));
    q.push_back(ev(S_T3, 5'b0, 16'h0, rb, 1'b0, 1'b0));
    if (kind == 1)
      repeat (4) q.push_back(ev(11'b0, 5'b0, 16'h0, 16'h0, 1'b0, 1'b1));
    else begin
      q.push_back(ev(S_T4, alu, 16'h0, rc, 1'b0, 1'b0));
      if (kind == 0) begin
        q.push_back(ev(S_T5, 5'b0, ra, 16'h0, 1'b1, 1'b0));
        if (!hold) q.push_back('0);
      end
    end
    n = kind == 0 ? 6 + waits : kind == 1 ? 8 + waits : 5 + waits;
    bus.IR = ir;
    bus.Run = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge Clock);
      #2;
      bus.Run = hold || (kind == 1 && k >= 3 + waits);
      bus.MemReady = (k - 1 == waits) || (kind == 1 && k > 3 + waits && k % 2 == 1);
    end
    if (kind == 0 && !hold) begin
      @(negedge Clock);
      #2;
    end
    if (kind != 0) begin
      bus.Run = 1'b0;
      Resetn = 1'b0;
      #1;
      chk("async_reset", act, '0);
      @(negedge Clock);
      #2;
      Resetn = 1'b1;
    end
  endtask
  initial begin
    bus.Run = 1'b0;
    bus.MemReady = 1'b0;
    bus.IR = 32'h0;
    #1 Resetn = 1'b0;
    repeat (2) @(negedge Clock);
    #2 Resetn = 1'b1;
    @(negedge Clock);
    #2;
    run_instr(32'h28918000, 0, 1'b0, 5'b01100, 16'h0002, 16'h0004, 16'h0008, 0);
    run_instr(32'h28918000, 3, 1'b0, 5'b01100, 16'h0002, 16'h0004, 16'h0008, 0);
    run_instr(32'h18918000, 0, 1'b1, 5'b00011, 16'h0002, 16'h0004, 16'h0008, 0);
    run_instr(32'h18918000, 0, 1'b1, 5'b00011, 16'h0002, 16'h0004, 16'h0008, 0);
    run_instr(32'h18918000, 0, 1'b0, 5'b00011, 16'h0002, 16'h0004, 16'h0008, 0);
    run_instr(32'h30000000, 0, 1'b0, 5'b01011, 16'h0001, 16'h0001, 16'h0001, 0);
    run_instr(32'h28918000, 0, 1'b0, 5'b01100, 16'h0002, 16'h0004, 16'h0008, 2);
    run_instr(32'h22B38000, 1, 1'b0, 5'b00100, 16'h0020, 16'h0040, 16'h0080, 0);
    run_instr(32'hF8918000, 0, 1'b0, 5'b00000, 16'h0000, 16'h0004, 16'h0000, 1);
    run_instr(32'h00000000, 2, 1'b0, 5'b00000, 16'h0000, 16'h0001, 16'h0000, 1);
    repeat (3) @(negedge Clock);
    #2;
    chk("drain", 50'(q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
